mac_accumulator: RTL and testbench
==================================

# mac_accumulator

- Sits directly downstream of the multiplier in each processing element.
- Consumes the stream of `2*WORD_WIDTH`-bit unsigned products and sums one group of products (a dot-product row, terminated by `in_last`) into a wide accumulator.
- Presents each finished sum with its beat count and an overflow flag on a valid/ready output.
- Holds the result under backpressure while the partial-sum register stays ready for the next group.

## Interface
Parameters:
- `WORD_WIDTH`, 8 — operand width of the upstream multiplier; products are `2*WORD_WIDTH` bits.
- `ACC_WIDTH`, 32 — accumulator and result width; must be ≥ `2*WORD_WIDTH` (elaboration error otherwise).
- `CNT_WIDTH`, 8 — width of the beat counter.

Ports:
- `clk` in 1 — single clock; all state is on the rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — product beat valid.
- `in_ready` out 1 — block accepts a beat this cycle.
- `in_prod` in `2*WORD_WIDTH` — unsigned product; zero-extended to `ACC_WIDTH`.
- `in_last` in 1 — this beat closes the current group.
- `flush` in 1 — synchronous discard of the partial sum and count.
- `out_valid` out 1 — result valid.
- `out_ready` in 1 — consumer takes the result.
- `out_sum` out `ACC_WIDTH` — group sum, modulo `2^ACC_WIDTH`.
- `out_count` out `CNT_WIDTH` — beats in the group; saturates at `2^CNT_WIDTH-1`.
- `out_overflow` out 1 — at least one carry out of `ACC_WIDTH` occurred within the group.

## Operation
- **Accept rule:** a beat is accepted when `in_valid && in_ready`.
- **Ready equation:** `in_ready = !flush && (!out_valid || out_ready)`.
- **State:**
  - partial `acc`, `cnt`, `ovf` (sticky), plus an output holding register.
  - Two states: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
- **Non-last beat accepted:**
  - `acc <= acc + in_prod`.
  - `cnt <= sat(cnt+1)`.
  - `ovf <= ovf | carry`.
- **Last beat accepted:**
  - `out_sum <= acc + in_prod`, `out_count <= sat(cnt+1)`, `out_overflow <= ovf | carry`.
  - `acc`, `cnt`, `ovf` clear to 0.
  - State goes to FULL.
- **FULL:**
  - Outputs stay stable until `out_ready`.
  - On `out_ready` without a simultaneous last beat: go to EMPTY.
  - On `out_ready` with a simultaneous accepted last beat: load the new result and stay FULL (back-to-back, no bubble).
- **Single-beat group** (`in_last` on the first beat): `out_sum = in_prod`, `out_count = 1`.
- **flush:**
  - Clears `acc`, `cnt`, `ovf` next edge.
  - Has priority over `in_valid`; the beat is not accepted because `in_ready=0`.
  - Does not affect the output register or `out_valid`.
- **Counter:** saturates at all-ones and does not wrap; the sum itself wraps.

## Timing
- **Reset values** (all asynchronous to `reset_n` low):
  - `out_valid=0`, `out_sum=0`, `out_count=0`, `out_overflow=0`.
  - `acc=0`, `cnt=0`, `ovf=0`.
  - `in_ready` is forced 0 while `reset_n` is low.
- **Latency:** result is visible with `out_valid=1` in the cycle after the edge that accepts the last beat.
- **Throughput:**
  - One beat per cycle.
  - Input stalls only while FULL and `!out_ready`.
- **Reset mid-group:** the partial sum is lost; the first group after reset starts from 0.
- **Handshake rules:**
  - `out_*` must not change while `out_valid && !out_ready`.
  - `in_ready` does not depend on `in_valid`.

## Structure
- **Shared package `systolic_pkg`:**
  - default `ACC_WIDTH` and `CNT_WIDTH` constants;
  - the output state enum (EMPTY, FULL).
- **Sub-module:** none required. The adder with carry-out is inline; the output register is a one-entry skid in the same module.

## Test plan
All scenarios use `WORD_WIDTH=8`, `ACC_WIDTH=32`, `CNT_WIDTH=8` unless stated otherwise.
- **Basic group:** beats 10, 20, 30 (`in_last` on 30), `out_ready=1` → one cycle later `out_sum=60`, `out_count=3`, `out_overflow=0`, `out_valid` high for one cycle.
- **Overflow** (`ACC_WIDTH=16`): beats 65025, 65025 (last) → `out_sum=64514`, `out_overflow=1`. The next group 5 (last) gives `out_sum=5`, `out_overflow=0`.
- **Backpressure:** group 7 (last), then `out_ready=0` for 4 cycles → `out_sum=7` held stable and `in_ready=0`. Raising `out_ready` together with beat 9 (last) → next cycle `out_sum=9`, `out_valid` still 1.
- **Flush:** beats 100, 200, then `flush` with `in_valid=1` and beat 50, then 3 (last) → `out_sum=3`, `out_count=1`. The 50 beat is not accepted.
- **Count saturation:** 300 beats of value 1, last on the 300th → `out_sum=300`, `out_count=255`.
- **Reset mid-group:** beats 40, 40, `reset_n` low for 2 cycles, then 8 (last) → all outputs 0 during reset, then `out_sum=8`, `out_count=1`.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic processing-element datapath.
package systolic_pkg;

  localparam int WORD_WIDTH_DEFAULT = 8;
  localparam int ACC_WIDTH_DEFAULT  = 32;
  localparam int CNT_WIDTH_DEFAULT  = 8;

  // Occupancy of the one-entry result register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-stream input and result output of the accumulator, as one bundle.
interface mac_accumulator_if
  import systolic_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
);

  logic                    in_valid;
  logic                    in_ready;
  logic [2*WORD_WIDTH-1:0] in_prod;
  logic                    in_last;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_WIDTH-1:0]    out_sum;
  logic [CNT_WIDTH-1:0]    out_count;
  logic                    out_overflow;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_prod, in_last, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_prod, in_last, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

endinterface

// File: rtl/mac_accumulator.sv
// Sums groups of unsigned products into a wide accumulator and presents each
// finished group sum, beat count and overflow flag on a valid/ready output.
module mac_accumulator
  import systolic_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  mac_accumulator_if.slave bus
);

  // A product must always fit in the accumulator.
  if (ACC_WIDTH < 2*WORD_WIDTH) begin : g_width_check
    $error("mac_accumulator: ACC_WIDTH must be >= 2*WORD_WIDTH");
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] out_sum_q;
  logic [CNT_WIDTH-1:0] out_count_q;
  logic                 out_ovf_q;
  out_state_t           state;

  logic [ACC_WIDTH:0]   sum_ext;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 in_ready_int;
  logic                 accept;

  // Input stalls only while a result is held and not being taken; flush and
  // reset both block acceptance. Deliberately independent of in_valid.
  assign in_ready_int = reset_n && !bus.flush && ((state == EMPTY) || bus.out_ready);
  assign accept       = bus.in_valid && in_ready_int;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign sum_ext = {1'b0, acc} + (ACC_WIDTH+1)'(bus.in_prod);

  // Beat counter saturates at all-ones instead of wrapping.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // Partial-sum accumulation, result capture and output-register occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      state       <= EMPTY;
    end else begin
      if (bus.flush) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        if (bus.in_last) begin
          out_sum_q   <= sum_ext[ACC_WIDTH-1:0];
          out_count_q <= cnt_inc;
          out_ovf_q   <= ovf | sum_ext[ACC_WIDTH];
          acc         <= '0;
          cnt         <= '0;
          ovf         <= 1'b0;
        end else begin
          acc <= sum_ext[ACC_WIDTH-1:0];
          cnt <= cnt_inc;
          ovf <= ovf | sum_ext[ACC_WIDTH];
        end
      end

      if (accept && bus.in_last) begin
        state <= FULL;
      end else if (bus.out_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.in_ready     = in_ready_int;
  assign bus.out_valid    = (state == FULL);
  assign bus.out_sum      = out_sum_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed, table-driven bench for mac_accumulator. Two instances share one
// stimulus stream: a 32-bit accumulator and a 16-bit one that exercises the
// carry-out / overflow path.
module tb_mac_accumulator;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        flush;
  logic        out_ready;

  int tests_run;
  int tests_failed;

  mac_accumulator_if #(.WORD_WIDTH(8), .ACC_WIDTH(32), .CNT_WIDTH(8)) if32 ();
  mac_accumulator_if #(.WORD_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) if16 ();

  assign if32.in_valid  = in_valid;
  assign if32.in_prod   = in_prod;
  assign if32.in_last   = in_last;
  assign if32.flush     = flush;
  assign if32.out_ready = out_ready;
  assign if16.in_valid  = in_valid;
  assign if16.in_prod   = in_prod;
  assign if16.in_last   = in_last;
  assign if16.flush     = flush;
  assign if16.out_ready = out_ready;

  mac_accumulator #(.WORD_WIDTH(8), .ACC_WIDTH(32), .CNT_WIDTH(8)) u_dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if32)
  );

  mac_accumulator #(.WORD_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) u_dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if16)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] prod;
    logic        last;
    logic        flsh;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_valid;
    logic [31:0] exp_sum32;
    logic [7:0]  exp_cnt;
    logic        exp_ovf32;
    logic [15:0] exp_sum16;
    logic        exp_ovf16;
  } vec_t;

  vec_t vecs[$];

  // Compare one value against its expectation and keep the tallies.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Check every output of both instances against one set of expectations.
  task automatic check_all(input string tag, input logic valid_e,
                           input logic [31:0] sum32_e, input logic [7:0] cnt_e,
                           input logic ovf32_e, input logic [15:0] sum16_e,
                           input logic ovf16_e);
    check_output({tag, " valid32"}, 32'(if32.out_valid), 32'(valid_e));
    check_output({tag, " sum32"}, if32.out_sum, sum32_e);
    check_output({tag, " cnt32"}, 32'(if32.out_count), 32'(cnt_e));
    check_output({tag, " ovf32"}, 32'(if32.out_overflow), 32'(ovf32_e));
    check_output({tag, " valid16"}, 32'(if16.out_valid), 32'(valid_e));
    check_output({tag, " sum16"}, 32'(if16.out_sum), 32'(sum16_e));
    check_output({tag, " cnt16"}, 32'(if16.out_count), 32'(cnt_e));
    check_output({tag, " ovf16"}, 32'(if16.out_overflow), 32'(ovf16_e));
  endtask

  task automatic check_ready(input string tag, input logic rdy_e);
    check_output({tag, " in_ready32"}, 32'(if32.in_ready), 32'(rdy_e));
    check_output({tag, " in_ready16"}, 32'(if16.in_ready), 32'(rdy_e));
  endtask

  // Drive one table row for one clock and check ready before and outputs after the edge.
  task automatic apply_stimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", idx);
    @(negedge clk);
    in_valid  = v.valid;
    in_prod   = v.prod;
    in_last   = v.last;
    flush     = v.flsh;
    out_ready = v.ordy;
    #1;
    check_ready(tag, v.exp_rdy);
    @(posedge clk);
    #1;
    check_all(tag, v.exp_valid, v.exp_sum32, v.exp_cnt, v.exp_ovf32,
              v.exp_sum16, v.exp_ovf16);
  endtask

  task automatic add_vec(input logic valid, input logic [15:0] prod, input logic last,
                         input logic flsh, input logic ordy, input logic exp_rdy,
                         input logic exp_valid, input logic [31:0] exp_sum32,
                         input logic [7:0] exp_cnt, input logic exp_ovf32,
                         input logic [15:0] exp_sum16, input logic exp_ovf16);
    vec_t v;
    v.valid = valid; v.prod = prod; v.last = last; v.flsh = flsh; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_valid = exp_valid; v.exp_sum32 = exp_sum32;
    v.exp_cnt = exp_cnt; v.exp_ovf32 = exp_ovf32; v.exp_sum16 = exp_sum16;
    v.exp_ovf16 = exp_ovf16;
    vecs.push_back(v);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_prod      = 16'd0;
    in_last      = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b1;

    //       vld   prod       last  flsh  ordy  rdy   oval  sum32          cnt    o32   sum16      o16
    // Basic group 10+20+30.
    add_vec(1'b1, 16'd10,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,      8'd0, 1'b0, 16'd0,     1'b0);
    add_vec(1'b1, 16'd20,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,      8'd0, 1'b0, 16'd0,     1'b0);
    add_vec(1'b1, 16'd30,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd60,     8'd3, 1'b0, 16'd60,    1'b0);
    add_vec(1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd60,     8'd3, 1'b0, 16'd60,    1'b0);
    // Overflow on the 16-bit instance, then back-to-back single-beat group.
    add_vec(1'b1, 16'd65025, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd60,     8'd3, 1'b0, 16'd60,    1'b0);
    add_vec(1'b1, 16'd65025, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd130050, 8'd2, 1'b0, 16'd64514, 1'b1);
    add_vec(1'b1, 16'd5,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5,      8'd1, 1'b0, 16'd5,     1'b0);
    add_vec(1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd5,      8'd1, 1'b0, 16'd5,     1'b0);
    // Backpressure: result 7 held for 4 stalled cycles, then 9 back-to-back.
    add_vec(1'b1, 16'd7,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd7,      8'd1, 1'b0, 16'd7,     1'b0);
    for (int k = 0; k < 4; k++)
      add_vec(1'b1, 16'd99,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7,      8'd1, 1'b0, 16'd7,     1'b0);
    add_vec(1'b1, 16'd9,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd9,      8'd1, 1'b0, 16'd9,     1'b0);
    add_vec(1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9,      8'd1, 1'b0, 16'd9,     1'b0);
    // Flush discards 100+200 and blocks the 50 beat.
    add_vec(1'b1, 16'd100,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9,      8'd1, 1'b0, 16'd9,     1'b0);
    add_vec(1'b1, 16'd200,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9,      8'd1, 1'b0, 16'd9,     1'b0);
    add_vec(1'b1, 16'd50,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9,      8'd1, 1'b0, 16'd9,     1'b0);
    add_vec(1'b1, 16'd3,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3,      8'd1, 1'b0, 16'd3,     1'b0);
    // Flush while holding a result leaves the result untouched.
    add_vec(1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3,      8'd1, 1'b0, 16'd3,     1'b0);
    add_vec(1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3,      8'd1, 1'b0, 16'd3,     1'b0);

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'd0, 8'd0, 1'b0, 16'd0, 1'b0);
    check_ready("reset", 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) apply_stimulus(i, vecs[i]);

    // Count saturation: 300 beats of 1.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_prod   = 16'd1;
      in_last   = (i == 299);
      flush     = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all("sat", 1'b1, 32'd300, 8'd255, 1'b0, 16'd300, 1'b0);

    // Reset in the middle of a group loses the partial sum.
    @(negedge clk);
    in_prod = 16'd40;
    in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_all("midrst", 1'b0, 32'd0, 8'd0, 1'b0, 16'd0, 1'b0);
    check_ready("midrst", 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_prod  = 16'd8;
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    check_all("postrst", 1'b1, 32'd8, 8'd1, 1'b0, 16'd8, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
